// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
//
// Runtime-programmable Moore serial pattern detector for framing and sync-word
// hunting on serial receive paths. The pattern length is selectable up to PAT_W
// bits, and the detector can run in overlapping or non-overlapping mode. Out of
// reset it is an overlapping "1010" detector.
//
// Ports:
//   clk          clock; all logic is rising-edge
//   rst          synchronous reset, active-high; dominates every other input
//   in_valid     in_bit is sampled this cycle
//   in_bit       serial data bit
//   cfg_load     load cfg_* this cycle; the bit presented this cycle is dropped
//   cfg_pattern  pattern; the first-received bit is cfg_pattern[cfg_len-1]
//   cfg_len      pattern length, valid range 1..PAT_W
//   cfg_overlap  1 = overlapping matches, 0 = restart the search after a match
//   clr_count    synchronous clear of match_count; wins over a coincident hit
//   det          high for exactly one clock per match (state MATCH)
//   match_count  saturating count of matches
//   cfg_err      high while the loaded configuration is invalid (state UNCFG)
// -----------------------------------------------------------------------------
module seq_detect_prog #(
    parameter int                 PAT_W   = 8,
    parameter int                 LEN_W   = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [PAT_W-1:0]   DEF_PAT = PAT_W'(8'b0000_1010),
    parameter logic [LEN_W-1:0]   DEF_LEN = LEN_W'(4),
    parameter logic               DEF_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             clr_count,
    output logic             det,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_HUNT  = 2'd1,
        ST_MATCH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q,   pat_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic               ovl_q,   ovl_d;
    logic [PAT_W-1:0]   hist_q,  hist_d;
    logic [LEN_W-1:0]   fill_q,  fill_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [PAT_W-1:0]   hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [PAT_W-1:0]   len_mask;
    logic               cfg_ok;
    logic               hit_cmp;
    logic               hit;

    // Candidate history/fill if the current bit were accepted. fill saturates
    // at PAT_W, which fits in LEN_W bits because 2**LEN_W > PAT_W.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], in_bit};
        fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        // Only the low len bits of history and pattern take part in the match.
        hit_cmp = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);
        cfg_ok  = (cfg_len != '0) && (int'(cfg_len) <= PAT_W);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        hit     = 1'b0;

        if (cfg_load) begin
            // New configuration restarts the search; the bit of this cycle is dropped.
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = cfg_ok ? ST_HUNT : ST_UNCFG;
        end else if (state_q != ST_UNCFG) begin
            if (in_valid) begin
                hit     = hit_cmp;
                hist_d  = hist_shift;
                fill_d  = (hit_cmp && !ovl_q) ? '0 : fill_inc;
                state_d = hit_cmp ? ST_MATCH : ST_HUNT;
            end else begin
                // MATCH lasts one clock even when no bit arrives.
                state_d = ST_HUNT;
            end
        end

        if (clr_count) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HUNT;
            pat_q   <= DEF_PAT;
            len_q   <= DEF_LEN;
            ovl_q   <= DEF_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign det         = (state_q == ST_MATCH);
    assign cfg_err     = (state_q == ST_UNCFG);
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_prog
//
// Bench for seq_detect_prog. Two instances share every input: one with the
// default counter width and one with CNT_W=2 for saturation. A bench model
// keeps the accepted bits in a queue and matches the newest len of them against
// the pattern; a negedge process compares both DUTs with it every cycle.
// Hand-computed literal checks pin the model at key points of the stimulus.
// -----------------------------------------------------------------------------
module tb_seq_detect_prog;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_bit;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             clr_count;

    logic             det_a, det_b;
    logic [7:0]       cnt_a;
    logic [1:0]       cnt_b;
    logic             err_a, err_b;

    seq_detect_prog #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .det(det_a), .match_count(cnt_a), .cfg_err(err_a)
    );

    seq_detect_prog #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .det(det_b), .match_count(cnt_b), .cfg_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    logic             m_ovl;
    logic             m_ok;
    bit               m_q[$];
    logic             m_det;
    int               m_cnt_a;
    int               m_cnt_b;

    always @(posedge clk) begin
        logic hit;
        hit = 1'b0;
        if (rst) begin
            m_pat   = 8'b0000_1010;
            m_len   = 4;
            m_ovl   = 1'b1;
            m_ok    = 1'b1;
            m_q.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            if (cfg_load) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                m_ok  = (m_len >= 1) && (m_len <= PAT_W);
                m_q.delete();
            end else if (in_valid && m_ok) begin
                m_q.push_back(in_bit);
                if (m_q.size() > PAT_W) void'(m_q.pop_front());
                if (m_q.size() >= m_len) begin
                    hit = 1'b1;
                    // newest bit pairs with pattern[0], older ones upward
                    for (int k = 0; k < m_len; k++)
                        if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
                if (hit && !m_ovl) m_q.delete();
            end
            if (clr_count) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
            end else if (hit) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3)   m_cnt_b++;
            end
        end
        m_det = hit;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("det_a",   int'(det_a), int'(m_det));
            check("det_b",   int'(det_b), int'(m_det));
            check("cnt_a",   int'(cnt_a), m_cnt_a);
            check("cnt_b",   int'(cnt_b), m_cnt_b);
            check("cfgerr_a", int'(err_a), int'(!m_ok));
            check("cfgerr_b", int'(err_b), int'(!m_ok));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        cfg_load  = 1'b0;
        clr_count = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic clear_cnt();
        clr_count = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] s1;
        logic [5:0] s3;
        s1 = 6'b101010;   // sent MSB first
        s3 = 6'b110110;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset();
        check("lit_rst_det", int'(det_a), 0);
        check("lit_rst_cnt", int'(cnt_a), 0);
        check("lit_rst_err", int'(err_a), 0);

        // defaults, overlapping 1010
        for (int i = 5; i >= 0; i--) begin
            step(1'b1, s1[i]);
            if (i == 2) check("lit_ovl_det_bit4", int'(det_a), 1);
            if (i == 1) check("lit_ovl_det_bit5", int'(det_a), 0);
            if (i == 0) check("lit_ovl_det_bit6", int'(det_a), 1);
        end
        step(1'b0, 1'b0);
        check("lit_ovl_det_idle", int'(det_a), 0);
        check("lit_ovl_cnt", int'(cnt_a), 2);

        // non-overlapping 1010
        clear_cnt();
        load(8'b0000_1010, 4'd4, 1'b0);
        for (int i = 5; i >= 0; i--) step(1'b1, s1[i]);
        check("lit_novl_cnt", int'(cnt_a), 1);

        // len 3 "110", overlapping, idle cycle between bits
        clear_cnt();
        load(8'b0000_0110, 4'd3, 1'b1);
        for (int i = 5; i >= 0; i--) begin
            step(1'b1, s3[i]);
            if (i == 3) check("lit_len3_det_bit3", int'(det_a), 1);
            step(1'b0, 1'b0);
            if (i == 3) check("lit_len3_det_idle", int'(det_a), 0);
        end
        check("lit_len3_cnt", int'(cnt_a), 2);

        // invalid lengths
        load(8'b0000_1010, 4'd0, 1'b1);
        check("lit_len0_err", int'(err_a), 1);
        for (int i = 3; i >= 0; i--) step(1'b1, s1[i]);
        check("lit_len0_cnt", int'(cnt_a), 2);
        load(8'b0000_1010, 4'd9, 1'b1);
        check("lit_len9_err", int'(err_a), 1);
        for (int i = 3; i >= 0; i--) step(1'b1, s1[i]);
        check("lit_len9_det", int'(det_a), 0);
        load(8'b0000_1010, 4'd4, 1'b1);
        check("lit_reload_err", int'(err_a), 0);
        for (int i = 3; i >= 0; i--) step(1'b1, s1[i]);
        check("lit_reload_cnt", int'(cnt_a), 3);

        // saturation on the 2-bit counter, then clear coincident with a hit
        do_reset();
        for (int r = 0; r < 6; r++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        check("lit_sat_cnt_a", int'(cnt_a), 5);
        check("lit_sat_cnt_b", int'(cnt_b), 3);
        step(1'b1, 1'b1);
        clr_count = 1'b1;
        step(1'b1, 1'b0);
        check("lit_clrhit_det", int'(det_a), 1);
        check("lit_clrhit_cnt_a", int'(cnt_a), 0);
        check("lit_clrhit_cnt_b", int'(cnt_b), 0);

        // reset mid-stream
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        do_reset();
        step(1'b1, 1'b0);
        check("lit_rstmid_det", int'(det_a), 0);

        // cfg_load drops a completing bit
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        cfg_pattern = 8'b0000_1010; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_load = 1'b1;
        step(1'b1, 1'b0);
        check("lit_lddrop_det", int'(det_a), 0);
        for (int i = 3; i >= 0; i--) step(1'b1, s1[i]);
        check("lit_after_ld_det", int'(det_a), 1);
        check("lit_after_ld_cnt", int'(cnt_a), 1);
        step(1'b0, 1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Runtime-programmable, parametrised Moore serial pattern detector. It is the next generation of the team's fixed 4-bit sequence detectors.
- Pattern length is selectable up to PAT_W bits, and overlap versus non-overlap matching is selectable.
- Input is qualified by a valid strobe, with a saturating match counter and configuration-error flag.
- Sits on serial receive paths (framing/sync-word hunt). Out of reset it behaves as an overlapping "1010" detector.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of the length field; must satisfy 2**LEN_W > PAT_W.
- CNT_W, 8, match-counter width.
- DEF_PAT, 8'b0000_1010, reset pattern (PAT_W bits).
- DEF_LEN, 4, reset pattern length.
- DEF_OVL, 1, reset overlap mode.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  load cfg_* this cycle.
- cfg_pattern  in  PAT_W  pattern; first-received bit is cfg_pattern[cfg_len-1], last is cfg_pattern[0]; bits >= cfg_len ignored.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = restart after a match.
- clr_count  in  1  synchronous clear of match_count.
- det  out  1  Moore output; high exactly while FSM is in MATCH.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  high while loaded config is invalid.

Behaviour:
- Reset (rst=1 at clock edge):
  - pattern=DEF_PAT, len=DEF_LEN, overlap=DEF_OVL.
  - history=0, fill=0, state=HUNT.
  - det=0, match_count=0, cfg_err=0.
  - Reset dominates all other inputs, including mid-stream and mid-MATCH.
- Internal registers:
  - history: PAT_W-bit shift register, shifted left with in_bit entering at bit 0.
  - fill: count of valid bits held, saturating at PAT_W.
- States:
  - UNCFG: config invalid; bits are ignored; det=0; cfg_err=1.
  - HUNT: searching; det=0.
  - MATCH: det=1; lasts exactly one clock.
- Accepted bit: in_valid=1, state != UNCFG, cfg_load=0.
  - Next history h' = {history[PAT_W-2:0], in_bit}.
  - Next fill f' = min(fill+1, PAT_W).
  - Hit when f' >= len and h'[len-1:0] == pattern[len-1:0].
- Transitions:
  - HUNT or MATCH, on accepted bit with hit: go to MATCH, and match_count increments, saturating at 2**CNT_W-1.
  - HUNT or MATCH, otherwise: go to HUNT. MATCH always leaves after one cycle; back-to-back MATCH is allowed when the next accepted bit hits again.
  - Overlap=0: on a hit, fill is cleared to 0 instead of f'. Overlap=1: fill keeps f'.
  - Latency: det rises on the clock edge that samples the completing bit, and is visible the cycle after that bit is presented.
- in_valid=0: history and fill hold; a MATCH state still exits to HUNT next edge.
- cfg_load=1:
  - Config registers load; history=0, fill=0. The in_bit presented that cycle is dropped, even if in_valid=1.
  - If cfg_len==0 or cfg_len>PAT_W: go to UNCFG, cfg_err=1.
  - Otherwise: go to HUNT, cfg_err=0.
  - match_count is not affected.
- clr_count=1: match_count=0 next edge. If it coincides with a hit, clear wins (count=0).
- UNCFG exits only via a valid cfg_load or rst.

Test Plan:
- Defaults after rst, stream 1,0,1,0,1,0 (in_valid=1 each cycle) -> det pulses one cycle after bits 4 and 6; match_count=2.
- cfg_load pattern=8'b0000_1010, len=4, overlap=0, same stream -> single det pulse after bit 4; match_count=1.
- cfg_load pattern=8'b0000_0110, len=3, overlap=1, stream 1,1,0,1,1,0 with in_valid=0 idle cycles between every bit -> det pulses after bits 3 and 6, each high exactly one cycle; match_count=2.
- cfg_load with len=0, then len=9 -> cfg_err=1, stream 1,0,1,0 gives det=0 and count unchanged. Then a valid cfg_load (len=4) -> cfg_err=0, detection resumes.
- CNT_W=2 build with defaults, stream (1,0) x 6 -> 5 matches, match_count saturates at 3. Then clr_count coincident with a hit -> match_count=0.
- Stream 1,0,1 then rst for one cycle, then 0 -> no det. Also cfg_load coincident with a completing in_bit -> bit dropped, det stays 0.
